// File: rtl/seq_tx_pkg.sv
// Shared definitions for the seq_tx serialiser: FSM encoding, default width,
// and the effective-length rule used when a frame is loaded.
package seq_tx_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    // A length of 0, or one longer than the register, means a full-width frame.
    function automatic int eff_len(input logic [3:0] len, input int data_w);
        if (len == 4'd0 || int'(len) > data_w) begin
            return data_w;
        end
        return int'(len);
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// MSB-first shift register with a remaining-bit counter. A load consumes the
// first bit at once (presented on msb), so the counter holds the bits still to send.
module seq_tx_shreg
    import seq_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    localparam int CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        len,
    output logic              msb,
    output logic              last
);

    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] aligned;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_eff;

    // Left-align so that data[L-1] becomes the top bit; upper bits fall off.
    assign len_eff = CNT_W'(eff_len(len, DATA_W));
    assign aligned = data << (DATA_W - eff_len(len, DATA_W));
    assign msb     = load ? aligned[DATA_W-1] : sreg_q[DATA_W-1];
    assign last    = (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= aligned << 1;
            cnt_q  <= len_eff - 1'b1;
        end else if (advance && !last) begin
            sreg_q <= sreg_q << 1;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: loads a pattern, shifts it out MSB-first with
// hold-based stalling, then signals completion with a one-cycle done pulse.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] load_data,
    input  logic [3:0]        load_len,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              hold,
    output logic              x_out,
    output logic              x_valid,
    output logic              done,
    output logic [1:0]        state
);

    state_t state_q, state_d;
    logic   x_out_d, x_valid_d, done_d;
    logic   load, advance, msb, last;

    assign load_ready = (state_q == IDLE);
    assign load       = load_valid && load_ready;
    assign advance    = (state_q == SEND) && !hold;
    assign state      = state_q;

    seq_tx_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .data    (load_data),
        .len     (load_len),
        .msb     (msb),
        .last    (last)
    );

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        x_out_d   = x_out;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                x_out_d = 1'b0;
                if (load) begin
                    state_d   = SEND;
                    x_out_d   = msb;
                    x_valid_d = 1'b1;
                end
            end
            SEND: begin
                // A held cycle keeps x_out and leaves the shift register untouched.
                if (!hold) begin
                    if (last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        x_out_d = 1'b0;
                    end else begin
                        x_out_d   = msb;
                        x_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                x_out_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                x_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_out   <= x_out_d;
            x_valid <= x_valid_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: stimulus pushes each accepted frame's bit
// sequence and done marker; a negedge monitor pops and compares.
module tb_seq_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] load_data;
    logic [3:0]    load_len;
    logic          load_valid;
    logic          load_ready;
    logic          hold;
    logic          x_out;
    logic          x_valid;
    logic          done;
    logic [1:0]    state;

    typedef struct {
        bit is_done;
        bit val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_tx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [3:0] len);
        return (len == 4'd0 || int'(len) > DW) ? DW : int'(len);
    endfunction

    // Expected stream: bits data[L-1] .. data[0], then one done cycle.
    task automatic push_frame(input logic [DW-1:0] d, input logic [3:0] len);
        exp_t e;
        for (int i = eff(len) - 1; i >= 0; i--) begin
            e.is_done = 1'b0;
            e.val     = d[i];
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.val     = 1'b0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (x_valid || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'({x_valid, done}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("mon_kind", 32'({x_valid, done}), e.is_done ? 32'd1 : 32'd2);
                check("mon_bit", 32'(x_out), e.is_done ? 32'd0 : 32'(e.val));
            end
        end
    end

    // One frame with an optional hold window of hold_n cycles after bit hold_at.
    // Period o is the cycle after edge N+o-1, where N is the accept edge.
    task automatic run_frame(input logic [DW-1:0] d, input logic [3:0] len,
                             input int hold_at, input int hold_n);
        int L, last_o;
        bit in_hold;
        L      = eff(len);
        last_o = L + hold_n + 2;
        @(posedge clk); #1;
        load_data  = d;
        load_len   = len;
        load_valid = 1'b1;
        hold       = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("ready_before_accept", 32'(load_ready), 32'd1);
        @(posedge clk);
        push_frame(d, len);
        for (int o = 1; o <= last_o; o++) begin
            #1;
            if (hold_n > 0 && o >= hold_at && o < hold_at + hold_n)
                hold = 1'b1;
            else if (o == L + hold_n + 1)
                hold = 1'($urandom_range(0, 1));
            else
                hold = 1'b0;
            load_valid = (o <= L + hold_n + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            load_data  = DW'($urandom);
            load_len   = 4'($urandom);
            @(negedge clk);
            in_hold = (hold_n > 0) && (o > hold_at) && (o <= hold_at + hold_n);
            check("x_valid", 32'(x_valid), 32'((o <= L + hold_n) && !in_hold));
            check("done", 32'(done), 32'(o == L + hold_n + 1));
            check("load_ready", 32'(load_ready), 32'(o == last_o));
            if (in_hold) check("hold_x_out", 32'(x_out), 32'(d[L - hold_at]));
            if (o != last_o) @(posedge clk);
        end
    endtask

    task automatic reset_mid_frame(input logic [DW-1:0] d);
        @(posedge clk); #1;
        load_data  = d;
        load_len   = 4'd8;
        load_valid = 1'b1;
        hold       = 1'b0;
        @(posedge clk);
        push_frame(d, 4'd8);
        #1 load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_x_valid", 32'(x_valid), 32'd0);
        check("mid_rst_x_out", 32'(x_out), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(load_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({x_valid, done}), 32'd0);
            check("post_rst_ready", 32'(load_ready), 32'd1);
        end
    endtask

    // load_valid held high: accepts land every L+2 edges, data toggling each cycle.
    task automatic back_to_back(input int n_edges);
        int            next_acc;
        logic [DW-1:0] base, d;
        logic [3:0]    len;
        next_acc = 0;
        base     = DW'($urandom);
        @(posedge clk); #1;
        hold = 1'b0;
        for (int e = 0; e < n_edges; e++) begin
            d          = e[0] ? ~base : base;
            len        = 4'($urandom);
            load_data  = d;
            load_len   = len;
            load_valid = 1'b1;
            @(negedge clk);
            check("b2b_ready", 32'(load_ready), 32'(e == next_acc));
            @(posedge clk);
            if (e == next_acc) begin
                push_frame(d, len);
                next_acc += eff(len) + 2;
            end
            #1;
        end
        load_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("b2b_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, hn, ha;
        rst        = 1'b1;
        load_data  = '0;
        load_len   = '0;
        load_valid = 1'b0;
        hold       = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        run_frame(8'b1011_0010, 4'd8, 0, 0);
        run_frame(8'hFF, 4'd3, 0, 0);
        run_frame(8'h5A, 4'd0, 0, 0);
        run_frame(8'hC3, 4'd12, 0, 0);
        run_frame(8'b1100_0000, 4'd8, 2, 3);
        run_frame(8'h01, 4'd1, 0, 0);
        run_frame(8'h1D, 4'd5, 5, 2);
        run_frame(8'h96, 4'd6, 1, 1);

        reset_mid_frame(8'hA7);
        run_frame(8'h3C, 4'd8, 0, 0);

        for (int f = 0; f < 20; f++) begin
            load_len = 4'($urandom);
            L  = eff(load_len);
            hn = $urandom_range(0, 3);
            ha = (hn > 0) ? $urandom_range(1, L) : 0;
            run_frame(DW'($urandom), load_len, ha, hn);
        end

        back_to_back(80);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
